// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial transmitter for a 10-bit word.
// The line idles high. Each frame is a start bit (0), the data bits LSB first,
// an optional even-parity bit, and a stop bit (1).
// Every bit lasts CLKS_PER_BIT clocks.
// Define SEQ_FRAME_TX_PARITY_EN to add the parity bit (13-bit frame).
// Without it the frame has 12 bits.
// o_frame_done pulses in the last stop cycle and is meant to advance an upstream counter.
// That counter feeds i_data.
// All outputs are registered from the next-state values, so no input reaches an output
// combinationally.
module seq_frame_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [9:0] i_data,
  output logic       o_frame_done,
  output logic       o_tx,
  output logic       o_busy
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_IDX = 4'd9;

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity over the latched word: XOR of all ten bits.
  function automatic logic even_parity(input logic [9:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  idx_r, idx_s;
  logic [9:0]  word_r, word_s;
  logic        tx_r, tx_s;
  logic        done_r, done_s;
  logic        busy_r, busy_s;
  logic        bit_end_s;

  // Next-state, bit timing and next-cycle output values.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + 16'd1;
    idx_s     = idx_r;
    word_s    = word_r;
    bit_end_s = (cnt_r == LAST_CNT);

    case (state_r)
      IDLE: begin
        cnt_s = 16'd0;
        if (i_enable) begin
          word_s  = i_data;
          state_s = START;
        end else begin
          word_s = word_r;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_s   = 16'd0;
          idx_s   = 4'd0;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = 16'd0;
          if (idx_r == LAST_IDX) begin
            idx_s = 4'd0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          cnt_s   = 16'd0;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_s   = 16'd0;
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        cnt_s   = 16'd0;
        idx_s   = 4'd0;
        state_s = IDLE;
      end
    endcase

    // Outputs for the coming cycle, derived from where the FSM is going.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = word_s[idx_s];
`ifdef SEQ_FRAME_TX_PARITY_EN
      PARITY:  tx_s = even_parity(word_s);
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == STOP) && (cnt_s == LAST_CNT);
  end

  // State, timing and output registers; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 4'd0;
      word_r  <= 10'd0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      word_r  <= word_s;
      tx_r    <= tx_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign o_tx         = tx_r;
  assign o_frame_done = done_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx with CLKS_PER_BIT=4.
// It uses a per-cycle reference model and a word scoreboard.
// Latched words are pushed when the model sees a latch.
// They are popped when the DUT pulses o_frame_done, and are compared with the word
// decoded from o_tx.
// A table of vectors and hand-written sequences cover reset, back-to-back frames,
// mid-frame reset and enable drop.
`timescale 1ns/1ps
module tb_seq_frame_tx;

  localparam int CPB = 4;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [9:0] i_data;
  logic       o_frame_done;
  logic       o_tx;
  logic       o_busy;

  logic [9:0] tb_data;
  logic [9:0] ctr;
  logic       use_ctr;
  logic       ctr_clr;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  assign i_data = use_ctr ? ctr : tb_data;

  // Upstream word counter: advances on each frame-done pulse.
  always_ff @(posedge i_clk) begin
    if (ctr_clr) ctr <= 10'd0;
    else if (o_frame_done) ctr <= ctr + 10'd1;
  end

  seq_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_data       (i_data),
    .o_frame_done (o_frame_done),
    .o_tx         (o_tx),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected line bits of one frame, index 0 sent first.
  function automatic logic [12:0] frame_bits(input logic [9:0] d);
    logic [12:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[10:1] = d;
`ifdef SEQ_FRAME_TX_PARITY_EN
    f[11] = ^d;
    f[12] = 1'b1;
`else
    f[11] = 1'b1;
`endif
    return f;
  endfunction

  // Reference model and scoreboard state
  logic [9:0]  exp_q[$];
  logic [9:0]  dec_q[$];
  int          start_q[$];
  bit          pred_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_cyc = 0;
  int          bi;
  logic [12:0] m_bits = '1;
  logic [12:0] dec_bits = '0;
  logic [9:0]  w;
  logic        p_tx, p_busy, p_done;
  logic        prev_busy = 1'b0;
  int          cyc = 0;

  // Per-cycle model: compare outputs to last prediction, then advance with current inputs
  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (pred_valid) begin
        chk("cyc_tx", int'(o_tx), int'(p_tx));
        chk("cyc_busy", int'(o_busy), int'(p_busy));
        chk("cyc_done", int'(o_frame_done), int'(p_done));
      end
      if (o_busy === 1'b1 && prev_busy == 1'b0) start_q.push_back(cyc);
      prev_busy = (o_busy === 1'b1);
      if (m_active && (m_cyc % CPB) == CPB / 2) begin
        bi = m_cyc / CPB;
        dec_bits[bi[3:0]] = o_tx;
      end
      if (o_frame_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_frame", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("sb_word", int'(dec_bits[10:1]), int'(w));
          dec_q.push_back(dec_bits[10:1]);
        end
      end
      if (i_reset) begin
        if (m_active && exp_q.size() > 0) void'(exp_q.pop_back());
        m_active   = 1'b0;
        pred_valid = 1'b1;
      end else if (!m_active) begin
        if (i_enable && pred_valid) begin
          m_active = 1'b1;
          m_cyc    = 0;
          m_bits   = frame_bits(i_data);
          exp_q.push_back(i_data);
        end
      end else begin
        m_cyc++;
        if (m_cyc == FRAME_CYC) m_active = 1'b0;
      end
      if (m_active) begin
        bi     = m_cyc / CPB;
        p_tx   = m_bits[bi[3:0]];
        p_busy = 1'b1;
        p_done = (m_cyc == FRAME_CYC - 1);
      end else begin
        p_tx   = 1'b1;
        p_busy = 1'b0;
        p_done = 1'b0;
      end
    end
  end

  // Pulse i_enable for one cycle with word d, then watch the frame from the first post-latch cycle
  task automatic send_word(input logic [9:0] d, output int lat, output int bc,
                           output int lb, output int sb, output int np);
    tb_data  = d;
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    tb_data  = ~d;
    lat = -1; bc = 0; lb = -1; sb = -1; np = 0;
    for (int n = 0; n < FRAME_CYC + 4; n++) begin
      if (o_busy) bc++;
      if (o_frame_done) begin
        np++;
        if (lat < 0) lat = n;
      end
      if (n == (NB - 2) * CPB + CPB / 2) lb = int'(o_tx);
      if (n == (NB - 1) * CPB + CPB / 2) sb = int'(o_tx);
      tick();
    end
  endtask

  typedef struct {
    logic [9:0] data;
    logic       par;
    logic       msb;
  } vec_t;

  vec_t vecs[7];
  int   lat, bc, lb, sb, np, low, c0;

  initial begin
    vecs[0] = '{10'h001, 1'b1, 1'b0};
    vecs[1] = '{10'h3FF, 1'b0, 1'b1};
    vecs[2] = '{10'h2AA, 1'b1, 1'b1};
    vecs[3] = '{10'h155, 1'b1, 1'b0};
    vecs[4] = '{10'h000, 1'b0, 1'b0};
    vecs[5] = '{10'h201, 1'b0, 1'b1};
    vecs[6] = '{10'h0F0, 1'b0, 1'b0};

    i_reset = 1'b1; i_enable = 1'b0; tb_data = 10'd0; use_ctr = 1'b0; ctr_clr = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0; ctr_clr = 1'b0;
    chk("reset_tx", int'(o_tx), 1);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_frame_done), 0);
    // data ignored while disabled
    tb_data = 10'h3C3;
    repeat (5) tick();
    chk("idle_tx", int'(o_tx), 1);
    chk("idle_busy", int'(o_busy), 0);

    // Table-driven single frames
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].data, lat, bc, lb, sb, np);
      chk($sformatf("v%0d_done_lat", i), lat, FRAME_CYC - 1);
      chk($sformatf("v%0d_done_cnt", i), np, 1);
      chk($sformatf("v%0d_busy_cyc", i), bc, FRAME_CYC);
`ifdef SEQ_FRAME_TX_PARITY_EN
      chk($sformatf("v%0d_parity_bit", i), lb, int'(vecs[i].par));
`else
      chk($sformatf("v%0d_bit9_before_stop", i), lb, int'(vecs[i].msb));
`endif
      chk($sformatf("v%0d_stop_bit", i), sb, 1);
    end

    // Enable held high with the counter attached from reset: words 0,1,2,3
    dec_q.delete();
    start_q.delete();
    i_reset = 1'b1; ctr_clr = 1'b1; use_ctr = 1'b1; i_enable = 1'b1;
    tick();
    i_reset = 1'b0; ctr_clr = 1'b0;
    np = 0;
    for (int n = 0; n < 4 * (FRAME_CYC + 1) + 20 && np < 4; n++) begin
      tick();
      if (o_frame_done) np++;
    end
    i_enable = 1'b0;
    repeat (10) tick();
    chk("ctr_done_cnt", np, 4);
    chk("ctr_words", dec_q.size(), 4);
    for (int k = 0; k < dec_q.size(); k++) chk($sformatf("ctr_word%0d", k), int'(dec_q[k]), k);
    chk("ctr_starts", start_q.size(), 4);
    for (int k = 1; k < start_q.size(); k++)
      chk($sformatf("ctr_period%0d", k), start_q[k] - start_q[k - 1], FRAME_CYC + 1);
    chk("ctr_final", int'(ctr), 4);
    use_ctr = 1'b0;

    // Reset during data bit 5 aborts the frame silently
    tb_data = 10'h0F0; i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    repeat (CPB + 5 * CPB + 1) tick();
    c0 = int'(ctr);
    chk("rst_pre_busy", int'(o_busy), 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_busy", int'(o_busy), 0);
    np = 0;
    for (int n = 0; n < FRAME_CYC + 10; n++) begin
      if (o_frame_done) np++;
      tick();
    end
    chk("rst_no_done", np, 0);
    chk("rst_ctr_held", int'(ctr), c0);

    // Enable dropped during START: frame completes once, then the line stays idle
    tb_data = 10'h155; i_enable = 1'b1;
    tick();
    repeat (2) tick();
    i_enable = 1'b0;
    np = 0;
    for (int n = 2; n < FRAME_CYC + 2; n++) begin
      if (o_frame_done) np++;
      tick();
    end
    low = 0; bc = 0;
    for (int n = 0; n < 3 * FRAME_CYC; n++) begin
      if (o_frame_done) np++;
      if (!o_tx) low++;
      if (o_busy) bc++;
      tick();
    end
    chk("endrop_done_cnt", np, 1);
    chk("endrop_tx_low", low, 0);
    chk("endrop_busy", bc, 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
